uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the UART block: recovers 8N1 frames from the `rx_in` line and delivers each byte on `dout` with a one-cycle `rx_valid` strobe. It is the receive-side counterpart of the transmit datapath.
- Framing matches the transmit side: start bit 0, then `din[0]` through `din[7]` (LSB first), then stop bit 1.
- Sits between the board pin (through its own synchronizer) and the consumer logic: FIFO or register file.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): `clk` cycles per bit period; must be ≥ 4.
- `clk` input 1: sole clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_in` input 1: asynchronous serial line; idles high.
- `dout` output 8: last correctly framed byte.
- `rx_valid` output 1: one-cycle pulse when `dout` is updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `parity_err` output 1: one-cycle parity-error pulse; see Configuration.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- `rx_in` passes through a 2-FF synchronizer, giving `rx_s`. All decisions use `rx_s`.
- States:
  - IDLE: `rx_s`==0 → START, clear bit counter `cnt`.
  - START: counts `CLKS_PER_BIT/2` cycles (integer division).
    - At the last count, `rx_s`==0 → DATA, reset `cnt`, `bit_idx`=0.
    - At the last count, `rx_s`==1 → IDLE (glitch rejected, no outputs).
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into `shift[bit_idx]`, LSB first.
    - After `bit_idx`==7 is sampled → PARITY if enabled, else STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - `rx_s`==1: `dout`←`shift`, pulse `rx_valid` (and `parity_err` if flagged) → IDLE.
    - `rx_s`==0: pulse `frame_err`, `dout` unchanged, `rx_valid` stays 0 → BREAK.
  - BREAK: wait for `rx_s`==1 → IDLE. A held-low line yields exactly one `frame_err`.
- `cnt` is `$clog2(CLKS_PER_BIT)` bits wide and wraps to 0 at `CLKS_PER_BIT-1`. `bit_idx` is 3 bits.
- `dout` changes only on a good stop bit; it holds between frames.
- Reset mid-frame abandons the frame with no pulses; the next falling edge starts a fresh frame.

## Timing
- Reset values: `dout`=8'h00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE, `cnt`=0, `shift`=0.
- Synchronizer latency is 2 cycles. Cycle 0 is the first cycle `rx_s`==0 in IDLE; `busy` rises at cycle 1.
- Start sample: cycle `CLKS_PER_BIT/2`. Data bit k is sampled at that point + (k+1)·`CLKS_PER_BIT`.
- Stop sample: 9·`CLKS_PER_BIT` after the start sample (10· with parity). `rx_valid`/`frame_err` are registered and assert the cycle after the stop sample. `busy` falls together with that pulse.
- Back-to-back frames: returning to IDLE at mid-stop-bit allows the next start edge to be detected with no gap cycles.
- Outputs are fully registered; there are no combinational paths from `rx_in`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame carries an even-parity bit after `din[7]`, sampled in a PARITY state one `CLKS_PER_BIT` after bit 7.
  - Mismatch against XOR of `shift` sets a sticky flag, cleared on entry to START.
  - On a good stop bit, `parity_err` pulses together with `rx_valid`, and `dout` is still updated.
- Undefined: no PARITY state, 8N1 only; `parity_err` is tied 0.

## Structure
- `uart_pkg`: state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), `DATA_BITS`=8, `START_BIT`=1'b0, `STOP_BIT`=1'b1. Shared with the transmit side.
- Sub-module `uart_sync2`: 2-FF synchronizer on `clk` with synchronous reset to 1 (line idle). Reusable for other async inputs.

## Test plan
Bench runs with `CLKS_PER_BIT`=16 and ideal bit timing unless noted.
- Frame 0xA5, good stop → `dout`=8'hA5; `rx_valid` high exactly 1 cycle; `frame_err`=0; `busy` low afterwards.
- Low glitch of 4 cycles on `rx_in` → returns to IDLE; `rx_valid`, `frame_err` and `dout` unchanged (8'h00 after reset).
- Frame 0x3C with stop bit 0, line then held low 40 cycles → one `frame_err` pulse; `dout` keeps its previous value; no new frame until the line returns high.
- Back-to-back 0x00 then 0xFF with no idle gap, plus ±5% bit-period skew → two `rx_valid` pulses, `dout` 8'h00 then 8'hFF.
- `rst` pulsed during DATA bit 3 of 0x55, then clean 0xC3 → all outputs at reset values, no pulse for the aborted frame; `dout`=8'hC3 afterwards.
- With `UART_RX_PARITY_EN`:
  - 0x01 with parity bit 0 → `parity_err` and `rx_valid` pulse the same cycle, `dout`=8'h01.
  - 0x03 with parity bit 0 → `parity_err` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver/transmitter state encoding.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 (idle line).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN to expect an even-parity
// bit between din[7] and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_e          state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_flag;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_s == START_BIT) begin
                        state <= START;
                        cnt   <= '0;
`ifdef UART_RX_PARITY_EN
                        par_flag <= 1'b0;
`endif
                    end
                end
                // Half-bit wait recentres sampling; a line back high here was a glitch.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= (rx_s == START_BIT) ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        if (rx_s != ^shift)
                            par_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                // Leaving at mid-stop-bit lets an immediately following start edge be caught.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s == STOP_BIT) begin
                            dout     <= shift;
                            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_flag;
`endif
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s == STOP_BIT)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16 (clock period 10 time units, bit = 160).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] dout;
    logic       rx_valid, frame_err, parity_err, busy;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .dout       (dout),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam int BP = 160;
`ifdef UART_RX_PARITY_EN
    // The extra parity bit pushes the last sample further out, so the fast frame is milder.
    localparam int BP_FAST = 154;
`else
    localparam int BP_FAST = 152;
`endif
    localparam int BP_SLOW = 168;

    int tests = 0;
    int fails = 0;

    // Pulse monitor, sampled on the falling edge.
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_perr_alone = 0, n_wide = 0;
    logic       prev_valid = 1'b0, prev_ferr = 1'b0;
    logic [7:0] vlog[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_valid++;
                vlog.push_back(dout);
            end
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if (parity_err && !rx_valid) n_perr_alone++;
            if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) n_wide++;
        end
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int bp);
        rx_in = 1'b0;
        #(bp);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            #(bp);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = p;
        #(bp);
`else
        if (p !== 1'b0 && p !== 1'b1) $display("note: parity argument unknown");
`endif
        rx_in = s;
        #(bp);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_dout;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int v0, f0, p0, pa0, w0;

        // par is the correct even-parity bit; stop=0 frames leave dout unchanged.
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1, 0};
        vecs[4] = '{8'hE7, 1'b0, 1'b0, 8'h80, 0, 1};
        vecs[5] = '{8'h7E, 1'b0, 1'b1, 8'h7E, 1, 0};

        repeat (5) @(negedge clk);
        check("reset dout", int'(dout), 8'h00);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset parity_err", int'(parity_err), 0);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 4-cycle low glitch is rejected at the start-bit midpoint.
        v0 = n_valid; f0 = n_ferr;
        @(posedge clk); #1 rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch busy during", int'(busy), 1);
        repeat (20) @(negedge clk);
        check("glitch busy after", int'(busy), 0);
        check("glitch rx_valid", n_valid - v0, 0);
        check("glitch frame_err", n_ferr - f0, 0);
        check("glitch dout", int'(dout), 8'h00);

        for (int i = 0; i < 6; i++) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr; w0 = n_wide;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, BP);
            rx_in = 1'b1;
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d dout", i), int'(dout), int'(vecs[i].exp_dout));
            check($sformatf("vec%0d rx_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d parity_err", i), n_perr - p0, 0);
            check($sformatf("vec%0d pulse width", i), n_wide - w0, 0);
            check($sformatf("vec%0d busy", i), int'(busy), 0);
        end

        // Bad stop bit followed by a held-low line: one frame_err, receiver parked.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, BP);
        repeat (40) @(negedge clk);
        check("break busy held", int'(busy), 1);
        check("break frame_err", n_ferr - f0, 1);
        check("break rx_valid", n_valid - v0, 0);
        check("break dout", int'(dout), 8'h7E);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("break busy released", int'(busy), 0);
        check("break single frame_err", n_ferr - f0, 1);

        // Back-to-back, slow then fast, no idle gap.
        v0 = n_valid; f0 = n_ferr; w0 = n_wide;
        vlog.delete();
        send_frame(8'h00, 1'b0, 1'b1, BP_SLOW);
        send_frame(8'hFF, 1'b0, 1'b1, BP_FAST);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("b2b rx_valid count", n_valid - v0, 2);
        check("b2b frame_err", n_ferr - f0, 0);
        check("b2b first byte", (vlog.size() > 0) ? int'(vlog[0]) : -1, 8'h00);
        check("b2b second byte", (vlog.size() > 1) ? int'(vlog[1]) : -1, 8'hFF);
        check("b2b pulse width", n_wide - w0, 0);
        check("b2b dout", int'(dout), 8'hFF);

        // Reset during data bit 3 of 0x55 (held until that frame is over).
        v0 = n_valid; f0 = n_ferr;
        fork
            send_frame(8'h55, 1'b0, 1'b1, BP);
            begin
                #(4 * BP + BP / 2);
                @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("rst dout", int'(dout), 8'h00);
                check("rst busy", int'(busy), 0);
                check("rst rx_valid", int'(rx_valid), 0);
                check("rst frame_err", int'(frame_err), 0);
                check("rst parity_err", int'(parity_err), 0);
            end
        join
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("aborted frame rx_valid", n_valid - v0, 0);
        check("aborted frame frame_err", n_ferr - f0, 0);
        v0 = n_valid;
        send_frame(8'hC3, 1'b0, 1'b1, BP);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("post-rst dout", int'(dout), 8'hC3);
        check("post-rst rx_valid", n_valid - v0, 1);

`ifdef UART_RX_PARITY_EN
        v0 = n_valid; p0 = n_perr; pa0 = n_perr_alone;
        send_frame(8'h01, 1'b0, 1'b1, BP);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("par bad parity_err", n_perr - p0, 1);
        check("par bad rx_valid", n_valid - v0, 1);
        check("par bad same cycle", n_perr_alone - pa0, 0);
        check("par bad dout", int'(dout), 8'h01);
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h03, 1'b0, 1'b1, BP);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("par good parity_err", n_perr - p0, 0);
        check("par good rx_valid", n_valid - v0, 1);
        check("par good dout", int'(dout), 8'h03);
`else
        pa0 = n_perr_alone;
        check("no-parity parity_err", pa0 + n_perr, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
